// File: rtl/gf_mul_serial.sv
// -----------------------------------------------------------------------------
// gf_mul_serial
//   Bit-serial GF(2^WIDTH) multiplier. It consumes one multiplier bit per clock,
//   MSB first (Horner's rule), and folds the modular reduction into each step.
//   The product is registered on out with a one-cycle o_done pulse. That lets it
//   drive a downstream adder's operand inputs and start strobe directly.
//
// Ports
//   i_clk    : clock, all state updates on rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_start  : start request, sampled only while idle
//   in_1     : multiplicand a, captured on the accepted start edge
//   in_2     : multiplier b, captured on the accepted start edge
//   out      : product a*b mod (x^WIDTH + POLY), held until the next completion
//   o_done   : one-cycle pulse on the cycle out is updated
//   o_busy   : high while a multiplication is in progress
// -----------------------------------------------------------------------------
module gf_mul_serial #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h1B
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic [WIDTH-1:0] out,
    output logic             o_done,
    output logic             o_busy
);

    localparam int             CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt, sh;
    logic [CW-1:0]    cnt;
    logic             accept, last;

    assign o_busy = (state == BUSY);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---------------- next state / step decode ----------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A start request while busy is dropped, not queued.
                if (cnt == '0) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One Horner step: multiply the accumulator by x, reduce the bit shifted out
    // of the top, then add a if the current multiplier bit is set.
    always_comb begin
        sh = {acc[WIDTH-2:0], 1'b0};
        if (acc[WIDTH-1]) sh = sh ^ POLY;
        acc_nxt = sh ^ (b_reg[cnt] ? a_reg : '0);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            out    <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (accept) begin
                a_reg <= in_1;
                b_reg <= in_2;
                acc   <= '0;
                cnt   <= CNT_TOP;
            end else if (o_busy) begin
                acc <= acc_nxt;
                cnt <= cnt - 1'b1;
                // The final step result goes straight to out in the same edge.
                if (last) begin
                    out    <= acc_nxt;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule
